// File: rtl/mod3.sv
// mod3: CH-channel one-entry buffered round-robin arbiter feeding one registered
// output carrying data+1 and parity. Optional transfer counter under MOD3_STATS_EN.
module mod3 #(
   parameter int CH = 4,
   parameter int W  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH-1:0]         in_valid,
   input  logic [CH*W-1:0]       in_data,
   output logic [CH-1:0]         in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W:0]            out_sum,
   output logic                  out_par,
   output logic [$clog2(CH)-1:0] out_ch,
   output logic [15:0]           xfer_cnt
);
   localparam int CW = $clog2(CH);

   // Handshake: a word moves on any edge where valid && ready are both high.
   // Producers may not wait on ready to raise valid; in_ready depends only on
   // registered state, so no combinational path exists from any input to it.

   logic [CH-1:0] full;
   logic [W-1:0]  hold_data [CH];
   logic [CW-1:0] ptr;
   logic [CW-1:0] gnt_idx;
   logic [CW-1:0] ptr_nxt;
   logic          gnt_any;
   logic          free;
   logic          grant;

   assign in_ready = ~full;
   assign free     = !out_valid || out_ready;
   assign grant    = free && gnt_any;

   // Scan from ptr upward, wrapping at CH; first full channel wins.
   always_comb begin
      int            c;
      logic [CW-1:0] cand;
      gnt_any = 1'b0;
      gnt_idx = '0;
      c       = 0;
      cand    = '0;
      for (int j = 0; j < CH; j++) begin
         c = int'(ptr) + j;
         if (c >= CH) c = c - CH;
         cand = CW'(c);
         if (!gnt_any && full[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign ptr_nxt = (gnt_idx == CW'(CH - 1)) ? '0 : gnt_idx + 1'b1;

   // Held words need no reset: full[] alone says whether they are meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CH; i++) begin
         if (in_valid[i] && !full[i]) hold_data[i] <= in_data[i*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full      <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_par   <= 1'b0;
         out_ch    <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (grant && gnt_idx == CW'(i)) full[i] <= 1'b0;
            else if (in_valid[i] && !full[i]) full[i] <= 1'b1;
         end
         if (free) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
               out_sum <= {1'b0, hold_data[gnt_idx]} + (W+1)'(1);
               out_par <= ^hold_data[gnt_idx];
               out_ch  <= gnt_idx;
               ptr     <= ptr_nxt;
            end
         end
      end
   end

`ifdef MOD3_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) xfer_cnt <= '0;
      else if (out_valid && out_ready && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
   end
`else
   assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mod3.sv
// Bench for mod3 (CH=4, W=3): directed vector table, then random traffic checked
// against a channel/queue-level reference model, then the transfer-counter run.
module tb_mod3;
   localparam int CH = 4;
   localparam int W  = 3;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CH-1:0]     in_valid = '0;
   logic [CH*W-1:0]   in_data = '0;
   logic [CH-1:0]     in_ready;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [W:0]        out_sum;
   logic              out_par;
   logic [CW-1:0]     out_ch;
   logic [15:0]       xfer_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mod3 #(.CH(CH), .W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_par(out_par), .out_ch(out_ch), .xfer_cnt(xfer_cnt)
   );

   // Reference model: each channel holds at most one word; the output slot
   // takes the next waiting channel in circular order after the last winner.
   int     m_word [CH];
   bit     m_has  [CH];
   int     m_next;
   bit     m_valid;
   int     m_sum, m_par, m_ch, m_cnt;

   task automatic model_step();
      bit had [CH];
      int k;
      if (rst) begin
         for (int i = 0; i < CH; i++) m_has[i] = 0;
         m_next = 0; m_valid = 0; m_sum = 0; m_par = 0; m_ch = 0; m_cnt = 0;
         return;
      end
      for (int i = 0; i < CH; i++) had[i] = m_has[i];
`ifdef MOD3_STATS_EN
      if (m_valid && out_ready && m_cnt < 65535) m_cnt++;
`endif
      if (!m_valid || out_ready) begin
         k = -1;
         for (int j = 0; j < CH; j++)
            if (k < 0 && had[(m_next + j) % CH]) k = (m_next + j) % CH;
         if (k >= 0) begin
            m_sum = m_word[k] + 1;
            m_par = $countones(m_word[k]) % 2;
            m_ch  = k;
            m_valid = 1;
            m_has[k] = 0;
            m_next = (k + 1) % CH;
         end else m_valid = 0;
      end
      for (int i = 0; i < CH; i++)
         if (in_valid[i] && !had[i]) begin
            m_word[i] = int'(in_data[i*W +: W]);
            m_has[i]  = 1;
         end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      logic [CH-1:0] er;
      for (int i = 0; i < CH; i++) er[i] = !m_has[i];
      chk("rand_valid", 32'(out_valid), 32'(m_valid));
      chk("rand_sum",   32'(out_sum),   32'(m_sum));
      chk("rand_par",   32'(out_par),   32'(m_par));
      chk("rand_ch",    32'(out_ch),    32'(m_ch));
      chk("rand_ready", 32'(in_ready),  32'(er));
      chk("rand_cnt",   32'(xfer_cnt),  32'(m_cnt));
   endtask

   typedef struct {
      logic            rst;
      logic [CH-1:0]   vld;
      logic [CH*W-1:0] data;
      logic            ordy;
      logic            ev;
      logic [W:0]      es;
      logic            ep;
      logic [CW-1:0]   ec;
      logic [CH-1:0]   er;
   } vec_t;

   vec_t vq[$];

   initial begin
      // reset with all valids high, then single word 3'b111 on channel 2
      vq.push_back('{1'b1, 4'hF, 12'hFFF, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'hF});
      vq.push_back('{1'b1, 4'hF, 12'hFFF, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'hF});
      vq.push_back('{1'b0, 4'h4, 12'h1C0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'hB});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd8, 1'b1, 2'd2, 4'hF});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 4'd8, 1'b1, 2'd2, 4'hF});
      // reset, then round robin 0,1,2,3 with words 0,1,5,7
      vq.push_back('{1'b1, 4'h0, 12'h000, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'hF});
      vq.push_back('{1'b0, 4'hF, 12'hF48, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'h0});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd1, 1'b0, 2'd0, 4'h1});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd2, 1'b1, 2'd1, 4'h3});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd6, 1'b0, 2'd2, 4'h7});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd8, 1'b1, 2'd3, 4'hF});
      // refill with words 2,3,4,6; first grant then 5 cycles of backpressure
      vq.push_back('{1'b0, 4'hF, 12'hD1A, 1'b1, 1'b0, 4'd8, 1'b1, 2'd3, 4'h0});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd3, 1'b1, 2'd0, 4'h1});
      for (int i = 0; i < 5; i++)
         vq.push_back('{1'b0, 4'h0, 12'h000, 1'b0, 1'b1, 4'd3, 1'b1, 2'd0, 4'h1});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd4, 1'b0, 2'd1, 4'h3});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd5, 1'b1, 2'd2, 4'h7});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 4'd7, 1'b0, 2'd3, 4'hF});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b0, 1'b1, 4'd7, 1'b0, 2'd3, 4'hF});
      vq.push_back('{1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 4'd7, 1'b0, 2'd3, 4'hF});
      // three channels full with out_valid high, then reset mid-operation
      vq.push_back('{1'b0, 4'h7, 12'h0D1, 1'b0, 1'b0, 4'd7, 1'b0, 2'd3, 4'h8});
      vq.push_back('{1'b0, 4'h8, 12'hA00, 1'b0, 1'b1, 4'd2, 1'b1, 2'd0, 4'h1});
      vq.push_back('{1'b1, 4'h0, 12'h000, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'hF});

      foreach (vq[n]) begin
         rst = vq[n].rst; in_valid = vq[n].vld; in_data = vq[n].data; out_ready = vq[n].ordy;
         tick();
         chk($sformatf("vec%0d_valid", n), 32'(out_valid), 32'(vq[n].ev));
         chk($sformatf("vec%0d_sum", n),   32'(out_sum),   32'(vq[n].es));
         chk($sformatf("vec%0d_par", n),   32'(out_par),   32'(vq[n].ep));
         chk($sformatf("vec%0d_ch", n),    32'(out_ch),    32'(vq[n].ec));
         chk($sformatf("vec%0d_ready", n), 32'(in_ready),  32'(vq[n].er));
      end
      chk("reset_cnt", 32'(xfer_cnt), 32'h0);

      // random traffic with occasional resets
      for (int n = 0; n < 2000; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = CH'($urandom);
         in_data   = (CH*W)'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         chk_model();
      end

      rst = 1'b0; in_valid = '1; out_ready = 1'b1;
`ifdef MOD3_STATS_EN
      for (int n = 0; n < 70100; n++) begin
         in_data = (CH*W)'($urandom);
         tick();
      end
      chk("stats_sat", 32'(xfer_cnt), 32'hFFFF);
      chk("stats_model", 32'(xfer_cnt), 32'(m_cnt));
      for (int n = 0; n < 20; n++) tick();
      chk("stats_hold", 32'(xfer_cnt), 32'hFFFF);
`else
      for (int n = 0; n < 200; n++) begin
         in_data = (CH*W)'($urandom);
         tick();
         chk("stats_off", 32'(xfer_cnt), 32'h0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mod3.md
# mod3

Parametrised successor to the fixed-width two-leaf wrapper: CH independent input channels of W-bit data, each buffered in a one-entry holding register, round-robin arbitrated onto one registered output with valid/ready handshake. Per transfer it produces the widened increment (W+1 bits) and the reduction parity (1 bit) of the selected word. It sits directly below the top level and replaces the direct, unbuffered leaf connections wherever several sources share one consumer.

## Interface
- CH, 4, number of input channels; legal range 2..16.
- W, 3, input data width; legal range 1..32.
- Derived, not overridable: CW = $clog2(CH).
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  CH  per-channel valid.
- in_data  input  CH*W  channel i at bits [i*W +: W].
- in_ready  output  CH  per-channel ready.
- out_valid  output  1  output register holds a transfer.
- out_ready  input  1  consumer accepts.
- out_sum  output  W+1  selected data + 1, zero-extended, no overflow possible.
- out_par  output  1  XOR-reduction of selected data.
- out_ch  output  CW  index of source channel.
- xfer_cnt  output  16  completed output transfers (see Configuration).

## Operation
- Per channel i: holding register hold_data[i], flag full[i]. in_ready[i] = !full[i]; no combinational path from in_valid or out_ready to in_ready.
- Accept on channel i when in_valid[i] && in_ready[i]: hold_data[i] <= in_data slice, full[i] <= 1.
- Output register "free" = !out_valid || out_ready.
- Arbiter: when free and any full[i], grant the first full channel scanning i = ptr, ptr+1, ... mod CH. On grant k: out_sum <= hold_data[k] + 1 (W+1 bits), out_par <= ^hold_data[k], out_ch <= k, out_valid <= 1, full[k] <= 0, ptr <= (k+1) mod CH.
- Free with no full channel: out_valid <= 0; out_sum/out_par/out_ch hold last values.
- Not free: no grant, ptr unchanged, out_* stable.
- Granted channel's in_ready is 0 during the grant cycle; it rises next cycle (no same-cycle refill).
- Arithmetic: all-ones input, e.g. W=3, 3'b111 -> out_sum 4'b1000. Parity of 0 is 0.

## Timing
- Reset (rst high at an edge): full = 0, ptr = 0, out_valid = 0, out_sum = 0, out_par = 0, out_ch = 0, xfer_cnt = 0; in_ready = all ones from the cycle after reset. Reset mid-transfer discards held and output data without completing.
- Latency: word accepted at edge t appears on out_* after edge t+1 (earliest), if output free at t+1.
- Throughput: one output per cycle while out_ready = 1 and ≥1 channel full; one word per channel per 2 cycles.
- out_valid, once high, stays high with stable out_sum/out_par/out_ch until the edge where out_ready = 1.
- Simultaneous accept on a channel and grant from another: both occur in the same cycle.
- Fairness: with all CH channels continuously full, each channel is granted exactly once per CH consecutive grants.
- ptr wrap: grant of channel CH-1 sets ptr to 0.

## Configuration
- MOD3_STATS_EN defined: xfer_cnt increments by 1 on each edge where out_valid && out_ready; saturates at 16'hFFFF; cleared by rst.
- Undefined: counter logic absent; xfer_cnt tied to 16'h0000. Port list identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with in_valid all ones -> after release out_valid = 0, out_sum = 0, out_ch = 0, xfer_cnt = 0, in_ready = 4'b1111.
- Single word: W=3, channel 2 sends 3'b111 at edge t, out_ready = 1 -> at t+1 out_valid = 1, out_sum = 4'b1000, out_par = 1, out_ch = 2; in_ready[2] = 1 at t+2.
- Round-robin: all 4 channels full at once, out_ready = 1 -> out_ch sequence 0,1,2,3 on consecutive cycles; refill all, next sequence again 0,1,2,3.
- Backpressure: out_ready = 0 for 5 cycles with out_valid = 1 -> out_sum/out_par/out_ch unchanged, no full flag cleared, ptr unchanged; releasing out_ready resumes in order.
- Reset mid-operation: rst asserted with 3 channels full and out_valid = 1 -> next cycle all clear, out_valid = 0, no transfer counted.
- Stats (MOD3_STATS_EN): 70000 consecutive transfers -> xfer_cnt = 16'hFFFF and holds; without macro xfer_cnt = 0 throughout.
